qpsk_bit_pair: RTL and testbench

- Serial-to-dibit front end for the QPSK differential coding stage.
- Collects a serial bit stream, arriving as one-cycle strobes, into 2-bit absolute-code symbols.
- Presents each symbol on a held output with a one-cycle valid pulse.
- Output feeds the absolute-to-relative code converter directly. Also handles pairing-phase resync and half-symbol timeout.

---
 rtl/qpsk_pkg.sv | 18 +
 rtl/qpsk_bit_pair_if.sv | 24 ++
 rtl/pn9_scrambler.sv | 32 +++
 rtl/qpsk_bit_pair.sv | 104 ++++++++++
 tb/tb_qpsk_bit_pair.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/qpsk_pkg.sv
// Shared types and constants for the QPSK serial-to-dibit front end.
package qpsk_pkg;

  // Absolute-code symbol: {first bit, second bit}
  typedef logic [1:0] dibit_t;

  // Pairing phase of the serial collector
  typedef enum logic {
    WAIT_MSB = 1'b0,
    WAIT_LSB = 1'b1
  } pair_state_t;

  // PN9 (x^9 + x^5 + 1) additive scrambler constants
  localparam logic [8:0]  PN9_SEED  = 9'h1FF;
  localparam int unsigned PN9_TAP_A = 8;   // stage 9, also the output stage
  localparam int unsigned PN9_TAP_B = 4;   // stage 5

endpackage : qpsk_pkg

// File: rtl/qpsk_bit_pair_if.sv
// Bit-strobe input and dibit output bundle of the QPSK pairing stage.
interface qpsk_bit_pair_if;
  import qpsk_pkg::*;

  logic   bit_in;
  logic   bit_en;
  logic   sync;
  dibit_t ab;
  logic   ab_vld;
  logic   half_err;

  // Source of bits / consumer of dibits
  modport master (
    output bit_in, bit_en, sync,
    input  ab, ab_vld, half_err
  );

  // The pairing stage itself
  modport slave (
    input  bit_in, bit_en, sync,
    output ab, ab_vld, half_err
  );

endinterface : qpsk_bit_pair_if

// File: rtl/pn9_scrambler.sv
// PN9 additive sequence generator (x^9 + x^5 + 1, seed 9'h1FF).
// pn_bit is the sequence bit for the current accepted strobe; when load is
// high it already reflects the reloaded seed so a bit arriving with load is
// scrambled with the first sequence bit.
module pn9_scrambler
  import qpsk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic adv,
  output logic pn_bit
);

  logic [8:0] r_lfsr;
  logic [8:0] w_cur;

  assign w_cur  = load ? PN9_SEED : r_lfsr;
  assign pn_bit = w_cur[PN9_TAP_A];

  // Advance once per accepted bit; reload seed on reset or load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= PN9_SEED;
    end else if (adv) begin
      r_lfsr <= {w_cur[7:0], w_cur[PN9_TAP_A] ^ w_cur[PN9_TAP_B]};
    end else if (load) begin
      r_lfsr <= PN9_SEED;
    end
  end

endmodule : pn9_scrambler

// File: rtl/qpsk_bit_pair.sv
// Serial-to-dibit front end for the QPSK differential coding stage.
// Optional PN9 scrambling of accepted bits is enabled by QPSK_SCRAMBLE_EN.
module qpsk_bit_pair
  import qpsk_pkg::*;
#(
  parameter int unsigned TO_W   = 8,
  parameter int unsigned TO_MAX = 200
) (
  input  logic            clk,
  input  logic            rst,
  qpsk_bit_pair_if.slave  bus
);

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TO_MAX - 1);

  generate
    if (TO_MAX < 1 || TO_MAX > (2**TO_W) - 1) begin : g_bad_to
      $error("qpsk_bit_pair: TO_MAX must be in 1 .. 2**TO_W-1");
    end
  endgenerate

  pair_state_t     r_state;
  logic            r_msb;
  logic [TO_W-1:0] r_cnt;
  dibit_t          r_ab;
  logic            r_ab_vld;
  logic            r_half_err;
  logic            w_bit;

`ifdef QPSK_SCRAMBLE_EN
  logic w_pn;

  pn9_scrambler u_pn9 (
    .clk    (clk),
    .rst    (rst),
    .load   (bus.sync),
    .adv    (bus.bit_en),
    .pn_bit (w_pn)
  );

  assign w_bit = bus.bit_in ^ w_pn;
`else
  assign w_bit = bus.bit_in;
`endif

  // Pairing FSM with gap timeout; all outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= WAIT_MSB;
      r_msb      <= 1'b0;
      r_cnt      <= '0;
      r_ab       <= '0;
      r_ab_vld   <= 1'b0;
      r_half_err <= 1'b0;
    end else begin
      r_ab_vld   <= 1'b0;
      r_half_err <= 1'b0;
      if (bus.sync) begin
        // Resync outranks pairing; a simultaneous bit starts a new pair
        r_half_err <= (r_state == WAIT_LSB);
        r_cnt      <= '0;
        if (bus.bit_en) begin
          r_msb   <= w_bit;
          r_state <= WAIT_LSB;
        end else begin
          r_msb   <= 1'b0;
          r_state <= WAIT_MSB;
        end
      end else begin
        unique case (r_state)
          WAIT_MSB: begin
            if (bus.bit_en) begin
              r_msb   <= w_bit;
              r_cnt   <= '0;
              r_state <= WAIT_LSB;
            end
          end
          WAIT_LSB: begin
            if (bus.bit_en) begin
              r_ab     <= {r_msb, w_bit};
              r_ab_vld <= 1'b1;
              r_msb    <= 1'b0;
              r_cnt    <= '0;
              r_state  <= WAIT_MSB;
            end else if (r_cnt == CNT_LAST) begin
              r_half_err <= 1'b1;
              r_msb      <= 1'b0;
              r_cnt      <= '0;
              r_state    <= WAIT_MSB;
            end else if (r_cnt != '1) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= WAIT_MSB;
        endcase
      end
    end
  end

  assign bus.ab       = r_ab;
  assign bus.ab_vld   = r_ab_vld;
  assign bus.half_err = r_half_err;

endmodule : qpsk_bit_pair

// File: tb/tb_qpsk_bit_pair.sv
// Self-checking bench for qpsk_bit_pair: directed steps followed by random
// strobes, all checked against a queue-level pairing model.
module tb_qpsk_bit_pair;

  localparam int unsigned TO_W   = 8;
  localparam int unsigned TO_MAX = 200;

  logic clk = 1'b0;
  logic rst = 1'b0;

  qpsk_bit_pair_if bus ();

  qpsk_bit_pair #(.TO_W(TO_W), .TO_MAX(TO_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pending half-dibit, idle gap count, scramble index
  bit         m_pend_v;
  bit         m_pend;
  int         m_gap;
  int         m_pn_idx;
  logic [1:0] m_ab;
  logic       m_vld;
  logic       m_he;
  bit         pn_seq [0:1023];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend_v = 0; m_pend = 0; m_gap = 0; m_pn_idx = 0;
    m_ab = 2'b00; m_vld = 0; m_he = 0;
  endtask

  task automatic model_step(input bit en, input bit b, input bit s);
    bit bb;
    m_vld = 0;
    m_he  = 0;
    if (s) m_pn_idx = 0;
    bb = b;
`ifdef QPSK_SCRAMBLE_EN
    if (en) begin
      bb = b ^ pn_seq[m_pn_idx % 1024];
      m_pn_idx++;
    end
`endif
    if (s) begin
      m_he     = m_pend_v;
      m_pend_v = en;
      m_pend   = bb;
      m_gap    = 0;
    end else if (en) begin
      if (m_pend_v) begin
        m_ab     = {m_pend, bb};
        m_vld    = 1;
        m_pend_v = 0;
      end else begin
        m_pend_v = 1;
        m_pend   = bb;
      end
      m_gap = 0;
    end else if (m_pend_v) begin
      m_gap++;
      if (m_gap == TO_MAX) begin
        m_he     = 1;
        m_pend_v = 0;
        m_gap    = 0;
      end
    end
  endtask

  // One clock: drive at negedge, check registered outputs just after posedge
  task automatic cyc(input bit en, input bit b, input bit s, input string tag);
    @(negedge clk);
    bus.bit_en = en;
    bus.bit_in = b;
    bus.sync   = s;
    @(posedge clk);
    #1;
    model_step(en, b, s);
    chk({tag, "_vld"}, 8'(bus.ab_vld),   8'(m_vld));
    chk({tag, "_he"},  8'(bus.half_err), 8'(m_he));
    chk({tag, "_ab"},  8'(bus.ab),       8'(m_ab));
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, tag);
  endtask

  initial begin
    // PN9 x^9+x^5+1 from all-ones: out[n+9] = out[n] ^ out[n+4]
    for (int i = 0; i < 9; i++) pn_seq[i] = 1'b1;
    for (int i = 0; i < 1024 - 9; i++) pn_seq[i + 9] = pn_seq[i] ^ pn_seq[i + 4];

    bus.bit_in = 0; bus.bit_en = 0; bus.sync = 0;
    model_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ab",  8'(bus.ab),       8'h00);
    chk("rst_vld", 8'(bus.ab_vld),   8'h00);
    chk("rst_he",  8'(bus.half_err), 8'h00);
    @(negedge clk);
    rst = 1'b1;

    // Consecutive strobes 1,0,1,1,0,0
    cyc(1, 1, 0, "c0"); cyc(1, 0, 0, "c1");
`ifndef QPSK_SCRAMBLE_EN
    chk("c1_ab_10", 8'(bus.ab), 8'h02);
`endif
    cyc(1, 1, 0, "c2"); cyc(1, 1, 0, "c3");
`ifndef QPSK_SCRAMBLE_EN
    chk("c3_ab_11", 8'(bus.ab), 8'h03);
`endif
    cyc(1, 0, 0, "c4"); cyc(1, 0, 0, "c5");
    idle(2, "c_hold");

    // Spaced strobes 0 ... 1
    cyc(1, 0, 0, "s0"); idle(4, "s_gap"); cyc(1, 1, 0, "s1");
`ifndef QPSK_SCRAMBLE_EN
    chk("s1_ab_01", 8'(bus.ab), 8'h01);
`endif
    idle(2, "s_hold");

    // Timeout: half_err exactly at idle clock TO_MAX
    cyc(1, 1, 0, "t0"); idle(TO_MAX - 1, "t_gap");
    chk("t_pre_he", 8'(bus.half_err), 8'h00);
    cyc(0, 0, 0, "t_exp");
`ifndef QPSK_SCRAMBLE_EN
    chk("t_he_pulse", 8'(bus.half_err), 8'h01);
`endif
    cyc(1, 0, 0, "t1"); cyc(1, 1, 0, "t2");
`ifndef QPSK_SCRAMBLE_EN
    chk("t2_ab_01", 8'(bus.ab), 8'h01);
`endif

    // Strobe on the expiry clock wins over timeout
    cyc(1, 1, 0, "w0"); idle(TO_MAX - 1, "w_gap"); cyc(1, 1, 0, "w1");

    // Sync with a simultaneous bit
    cyc(1, 1, 0, "y0"); cyc(1, 0, 1, "y1"); cyc(1, 1, 0, "y2");
`ifndef QPSK_SCRAMBLE_EN
    chk("y2_ab_01", 8'(bus.ab), 8'h01);
`endif
    idle(2, "y_hold");

    // Reset mid-pair is silent
    cyc(1, 0, 0, "r0");
    #2 rst = 1'b0;
    #1;
    chk("rmid_ab",  8'(bus.ab),       8'h00);
    chk("rmid_vld", 8'(bus.ab_vld),   8'h00);
    chk("rmid_he",  8'(bus.half_err), 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    cyc(1, 1, 0, "r1"); cyc(1, 1, 0, "r2");
`ifndef QPSK_SCRAMBLE_EN
    chk("r2_ab_11", 8'(bus.ab), 8'h03);
`endif

`ifdef QPSK_SCRAMBLE_EN
    // Zero input exposes the raw PN9 sequence; sync restarts it
    cyc(0, 0, 1, "pn_sync");
    for (int i = 0; i < 18; i++) cyc(1, 0, 0, "pn");
    cyc(0, 0, 1, "pn_resync");
    cyc(1, 0, 0, "pn2a"); cyc(1, 0, 0, "pn2b");
    chk("pn_restart_11", 8'(bus.ab), 8'h03);
`endif

    // Random traffic with occasional long gaps around the timeout boundary
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 39) == 0)
        idle(int'($urandom_range(TO_MAX - 3, TO_MAX + 3)), "rnd_gap");
      else
        cyc(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_qpsk_bit_pair
